// File: rtl/lib_grant_client.sv
// Requester-side front end for the programmable priority arbiter: forwards
// requests, captures a legal one-hot grant, locks the winner for a whole
// packet and rotates the one-hot priority after each tail transfer.
module lib_grant_client #(
   parameter int unsigned N     = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N*WIDTH-1:0]   i_data,
   input  logic [0:N-1]         i_valid,
   input  logic [0:N-1]         i_tail,
   output logic [0:N-1]         o_ready,
   output logic [0:N-1]         o_request,
   output logic [0:N-1]         o_priority,
   input  logic [0:N-1]         i_grant,
   output logic [WIDTH-1:0]     o_data,
   output logic                 o_valid,
   output logic                 o_tail,
   input  logic                 i_ready,
   output logic [0:N-1]         o_owner,
   output logic                 o_error
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

   state_e             state_q, state_d;
   logic [0:N-1]       owner_q, owner_d;
   logic [0:N-1]       prio_q, prio_d;
   logic               err_q, err_d;

   logic [0:N-1]       prio_rot;
   logic               grant_nonzero;
   logic               grant_legal;
   logic               own_valid;
   logic               own_tail;
   logic [WIDTH-1:0]   own_data;

   // A legal grant is exactly one-hot and only names requesters that asked.
   assign grant_nonzero = (i_grant != '0);
   assign grant_legal   = $onehot(i_grant) && ((i_grant & ~i_valid) == '0);

   // One-hot owner selects its flit, valid and tail (AND-OR mux).
   always_comb begin
      own_valid = 1'b0;
      own_tail  = 1'b0;
      own_data  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (owner_q[k]) begin
            own_valid = own_valid | i_valid[k];
            own_tail  = own_tail  | i_tail[k];
            own_data  = own_data  | i_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Next priority: the requester just after the finishing owner, wrapping.
   always_comb begin
      prio_rot = '0;
      for (int unsigned k = 0; k < N; k++) begin
         prio_rot[(k + 1) % N] = owner_q[k];
      end
   end

   // State, owner, priority and error registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         prio_q  <= {1'b1, {(N-1){1'b0}}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
         err_q   <= err_d;
      end
   end

   // Next-state: capture grant in IDLE, release lock on tail transfer.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      prio_d  = prio_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_nonzero) begin
               if (grant_legal) begin
                  state_d = LOCKED;
                  owner_d = i_grant;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOCKED: begin
            if (own_valid && i_ready && own_tail) begin
               state_d = IDLE;
               owner_d = '0;
               prio_d  = prio_rot;
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = '0;
         end
      endcase
   end

   // Outputs: requests while idle, owner's stream while locked.
   always_comb begin
      o_request = '0;
      o_ready   = '0;
      o_valid   = 1'b0;
      o_tail    = 1'b0;
      o_data    = '0;
      if (reset_n) begin
         case (state_q)
            IDLE: begin
               o_request = i_valid;
            end
            LOCKED: begin
               o_valid = own_valid;
               o_tail  = own_tail;
               o_data  = own_data;
               o_ready = owner_q & {N{i_ready}};
            end
            default: begin
               o_request = '0;
            end
         endcase
      end
   end

   assign o_priority = prio_q;
   assign o_owner    = owner_q;
   assign o_error    = err_q;

endmodule

// File: tb/tb_lib_grant_client.sv
// Bench for lib_grant_client: directed vector table, hand sequences for
// backpressure/bubble and mid-packet reset, then randomized traffic against
// an index-based reference model.
module tb_lib_grant_client;

   localparam int unsigned N = 4;
   localparam int unsigned W = 32;

   logic               clk;
   logic               reset_n;
   logic [N*W-1:0]     i_data;
   logic [0:N-1]       i_valid;
   logic [0:N-1]       i_tail;
   logic [0:N-1]       o_ready;
   logic [0:N-1]       o_request;
   logic [0:N-1]       o_priority;
   logic [0:N-1]       i_grant;
   logic [W-1:0]       o_data;
   logic               o_valid;
   logic               o_tail;
   logic               i_ready;
   logic [0:N-1]       o_owner;
   logic               o_error;

   int n_total;
   int n_pass;

   lib_grant_client #(.N(N), .WIDTH(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .i_tail     (i_tail),
      .o_ready    (o_ready),
      .o_request  (o_request),
      .o_priority (o_priority),
      .i_grant    (i_grant),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_tail     (o_tail),
      .i_ready    (i_ready),
      .o_owner    (o_owner),
      .o_error    (o_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [0:N-1] v, t, g;
      logic         r;
      logic [N*W-1:0] d;
      logic [0:N-1] e_req, e_rdy;
      logic         e_val, e_tail;
      logic [W-1:0] e_dat;
      logic [0:N-1] e_own, e_pri;
      logic         e_err;
   } row_t;

   row_t rows[$];

   function automatic logic [N*W-1:0] dat4(input logic [W-1:0] r0, r1, r2, r3);
      return {r3, r2, r1, r0};
   endfunction

   function automatic row_t mk(
      input logic [0:N-1] v, t, g, input logic r, input logic [N*W-1:0] d,
      input logic [0:N-1] e_req, e_rdy, input logic e_val, e_tail,
      input logic [W-1:0] e_dat, input logic [0:N-1] e_own, e_pri,
      input logic e_err);
      row_t x;
      x.v = v; x.t = t; x.g = g; x.r = r; x.d = d;
      x.e_req = e_req; x.e_rdy = e_rdy; x.e_val = e_val; x.e_tail = e_tail;
      x.e_dat = e_dat; x.e_own = e_own; x.e_pri = e_pri; x.e_err = e_err;
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic check_outs(input string tag,
      input logic [0:N-1] req, rdy, input logic val, tl,
      input logic [W-1:0] dat, input logic [0:N-1] own, pri, input logic err);
      chk({tag, ".request"},  64'(o_request),  64'(req));
      chk({tag, ".ready"},    64'(o_ready),    64'(rdy));
      chk({tag, ".valid"},    64'(o_valid),    64'(val));
      chk({tag, ".tail"},     64'(o_tail),     64'(tl));
      chk({tag, ".data"},     64'(o_data),     64'(dat));
      chk({tag, ".owner"},    64'(o_owner),    64'(own));
      chk({tag, ".priority"}, 64'(o_priority), 64'(pri));
      chk({tag, ".error"},    64'(o_error),    64'(err));
   endtask

   // Apply a row at posedge+1, check mid-cycle, advance to next posedge+1.
   task automatic apply_row(input string tag, input row_t x);
      i_valid = x.v; i_tail = x.t; i_grant = x.g; i_ready = x.r; i_data = x.d;
      #4;
      check_outs(tag, x.e_req, x.e_rdy, x.e_val, x.e_tail, x.e_dat,
                 x.e_own, x.e_pri, x.e_err);
      @(posedge clk);
      #1;
   endtask

   // Reference model state: plain indices rather than one-hot vectors.
   bit m_locked;
   int m_owner;
   int m_prio;
   bit m_err;

   function automatic logic [0:N-1] onehot_idx(input int i);
      logic [0:N-1] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset_n = 1'b0;
      i_valid = '0; i_tail = '0; i_grant = '0; i_ready = 1'b0; i_data = '0;

      // Reset values while held in reset.
      i_valid = 4'b1111;
      #12;
      check_outs("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, '0, 4'b0000, 4'b1000, 1'b0);
      i_valid = '0;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // single 1-flit packet from requester 1
      rows.push_back(mk(4'b0100, 4'b0100, 4'b0000, 1'b1, dat4(0, 32'hA5, 0, 0),
         4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 4'b1000, 0));
      rows.push_back(mk(4'b0100, 4'b0100, 4'b0100, 1'b1, dat4(0, 32'hA5, 0, 0),
         4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 4'b1000, 0));
      rows.push_back(mk(4'b0100, 4'b0100, 4'b0000, 1'b1, dat4(0, 32'hA5, 0, 0),
         4'b0000, 4'b0100, 1, 1, 32'hA5, 4'b0100, 4'b1000, 0));
      rows.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1, dat4(0, 0, 0, 0),
         4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0010, 0));
      // 3-flit packet from requester 0 while requester 2 stays valid
      rows.push_back(mk(4'b1010, 4'b0000, 4'b1000, 1'b1, dat4(1, 0, 32'hBB, 0),
         4'b1010, 4'b0000, 0, 0, 0, 4'b0000, 4'b0010, 0));
      rows.push_back(mk(4'b1010, 4'b0000, 4'b0000, 1'b1, dat4(1, 0, 32'hBB, 0),
         4'b0000, 4'b1000, 1, 0, 1, 4'b1000, 4'b0010, 0));
      rows.push_back(mk(4'b1010, 4'b0010, 4'b0000, 1'b1, dat4(2, 0, 32'hBB, 0),
         4'b0000, 4'b1000, 1, 0, 2, 4'b1000, 4'b0010, 0));
      rows.push_back(mk(4'b1010, 4'b1010, 4'b0000, 1'b1, dat4(3, 0, 32'hBB, 0),
         4'b0000, 4'b1000, 1, 1, 3, 4'b1000, 4'b0010, 0));
      rows.push_back(mk(4'b1010, 4'b0000, 4'b0000, 1'b1, dat4(0, 0, 32'hBB, 0),
         4'b1010, 4'b0000, 0, 0, 0, 4'b0000, 4'b0100, 0));
      // wrap-around: requester 3
      rows.push_back(mk(4'b0001, 4'b0001, 4'b0001, 1'b1, dat4(0, 0, 0, 32'hC3),
         4'b0001, 4'b0000, 0, 0, 0, 4'b0000, 4'b0100, 0));
      rows.push_back(mk(4'b0001, 4'b0001, 4'b0000, 1'b1, dat4(0, 0, 0, 32'hC3),
         4'b0000, 4'b0001, 1, 1, 32'hC3, 4'b0001, 4'b0100, 0));
      rows.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1, dat4(0, 0, 0, 0),
         4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b1000, 0));
      // illegal grants: unrequested bit, then multi-hot
      rows.push_back(mk(4'b0011, 4'b0000, 4'b0110, 1'b1, dat4(0, 0, 0, 0),
         4'b0011, 4'b0000, 0, 0, 0, 4'b0000, 4'b1000, 0));
      rows.push_back(mk(4'b0011, 4'b0000, 4'b0011, 1'b1, dat4(0, 0, 0, 0),
         4'b0011, 4'b0000, 0, 0, 0, 4'b0000, 4'b1000, 1));
      rows.push_back(mk(4'b0011, 4'b0000, 4'b0000, 1'b1, dat4(0, 0, 0, 0),
         4'b0011, 4'b0000, 0, 0, 0, 4'b0000, 4'b1000, 1));
      rows.push_back(mk(4'b0011, 4'b0000, 4'b0000, 1'b1, dat4(0, 0, 0, 0),
         4'b0011, 4'b0000, 0, 0, 0, 4'b0000, 4'b1000, 0));

      for (int i = 0; i < rows.size(); i++) begin
         apply_row($sformatf("vec%0d", i), rows[i]);
      end

      // Backpressure then bubble on requester 2's 3-flit packet.
      apply_row("bp_grant", mk(4'b0010, 4'b0000, 4'b0010, 1'b1, dat4(0, 0, 32'h11, 0),
         4'b0010, 4'b0000, 0, 0, 0, 4'b0000, 4'b1000, 0));
      apply_row("bp_stall0", mk(4'b0010, 4'b0000, 4'b0000, 1'b0, dat4(0, 0, 32'h11, 0),
         4'b0000, 4'b0000, 1, 0, 32'h11, 4'b0010, 4'b1000, 0));
      apply_row("bp_stall1", mk(4'b0010, 4'b0000, 4'b0000, 1'b0, dat4(0, 0, 32'h11, 0),
         4'b0000, 4'b0000, 1, 0, 32'h11, 4'b0010, 4'b1000, 0));
      apply_row("bp_flit1", mk(4'b0010, 4'b0000, 4'b0000, 1'b1, dat4(0, 0, 32'h11, 0),
         4'b0000, 4'b0010, 1, 0, 32'h11, 4'b0010, 4'b1000, 0));
      apply_row("bp_bubble", mk(4'b1100, 4'b1100, 4'b0000, 1'b1, dat4(5, 6, 32'h22, 0),
         4'b0000, 4'b0010, 0, 0, 32'h22, 4'b0010, 4'b1000, 0));
      apply_row("bp_flit2", mk(4'b0010, 4'b0000, 4'b0000, 1'b1, dat4(0, 0, 32'h22, 0),
         4'b0000, 4'b0010, 1, 0, 32'h22, 4'b0010, 4'b1000, 0));
      apply_row("bp_flit3", mk(4'b0010, 4'b0010, 4'b0000, 1'b1, dat4(0, 0, 32'h33, 0),
         4'b0000, 4'b0010, 1, 1, 32'h33, 4'b0010, 4'b1000, 0));
      apply_row("bp_idle", mk(4'b0000, 4'b0000, 4'b0000, 1'b1, dat4(0, 0, 0, 0),
         4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0001, 0));

      // Reset after flit 1 of 3 from requester 1.
      apply_row("rst_grant", mk(4'b0100, 4'b0000, 4'b0100, 1'b1, dat4(0, 32'h51, 0, 0),
         4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 4'b0001, 0));
      apply_row("rst_flit1", mk(4'b0100, 4'b0000, 4'b0000, 1'b1, dat4(0, 32'h51, 0, 0),
         4'b0000, 4'b0100, 1, 0, 32'h51, 4'b0100, 4'b0001, 0));
      i_data = dat4(0, 32'h52, 0, 0);
      reset_n = 1'b0;
      #2;
      check_outs("rst_async", 4'b0000, 4'b0000, 1'b0, 1'b0, '0, 4'b0000, 4'b1000, 1'b0);
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      apply_row("rst_after", mk(4'b0100, 4'b0000, 4'b0000, 1'b1, dat4(0, 32'h52, 0, 0),
         4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 4'b1000, 0));

      // Randomized traffic against the reference model.
      m_locked = 0; m_owner = 0; m_prio = 0; m_err = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic [0:N-1] v, t, g, e_req, e_rdy, e_own;
         logic r, e_val, e_tail;
         logic [W-1:0] e_dat;
         int sel, cnt;
         v = N'($urandom_range(0, 15));
         t = '0;
         for (int k = 0; k < N; k++) t[k] = ($urandom_range(0, 2) == 0);
         r = ($urandom_range(0, 3) != 0);
         g = '0;
         if (!m_locked) begin
            sel = $urandom_range(0, 4);
            if (sel <= 2 && v != '0) begin
               int p;
               p = $urandom_range(0, N - 1);
               while (!v[p]) p = (p + 1) % N;
               g = onehot_idx(p);
            end else if (sel == 3) begin
               g = N'($urandom_range(1, 15));
            end
         end
         i_valid = v; i_tail = t; i_grant = g; i_ready = r;
         for (int k = 0; k < N; k++) i_data[k*W +: W] = $urandom;

         e_req  = m_locked ? '0 : v;
         e_val  = m_locked && v[m_owner];
         e_tail = m_locked && t[m_owner];
         e_dat  = m_locked ? i_data[m_owner*W +: W] : '0;
         e_rdy  = (m_locked && r) ? onehot_idx(m_owner) : '0;
         e_own  = m_locked ? onehot_idx(m_owner) : '0;
         #4;
         check_outs($sformatf("rnd%0d", cyc), e_req, e_rdy, e_val, e_tail, e_dat,
                    e_own, onehot_idx(m_prio), m_err);
         @(posedge clk);
         // model update for this edge
         if (!m_locked) begin
            m_err = 0;
            if (g != '0) begin
               cnt = $countones(g);
               if (cnt == 1 && (g & ~v) == '0) begin
                  m_locked = 1;
                  for (int k = 0; k < N; k++) if (g[k]) m_owner = k;
               end else begin
                  m_err = 1;
               end
            end
         end else begin
            m_err = 0;
            if (v[m_owner] && r && t[m_owner]) begin
               m_locked = 0;
               m_prio = (m_owner + 1) % N;
            end
         end
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
